// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core.
// Latency: branch/jump 3, ALU/LUI/AUIPC/store 4, load 5 cycles, plus one cycle per memory wait cycle.
// Backpressure: mem_req/mem_we/mem_size held until mem_ready; MEM_TIMEOUT_EN bounds each wait and traps.

module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int RESET_FETCH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_size,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       reg_write_src,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Registered Moore outputs; pc_write splits into an unconditional (jump)
  // part and a branch part that is gated by the live comparator result.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_write_src;
    logic       trap;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{mem_size: 3'b010, default: '0};

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU encoding: {alt, funct3}; alt selects SUB (funct3=000) or SRA (funct3=101)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  state_t     state;
  state_t     nxt;
  ctl_t       ctl_q;
  ctl_t       nxt_ctl;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       f7b5_q;
  logic [6:0] dec_op;
  logic [2:0] dec_f3;
  logic       dec_f7b5;
  logic       xfer_done;
  logic       timeout;
  logic       retire;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // funct7[5] only means SUB for register ADD, and SRA/SRAI for right shifts;
  // ADDI with a negative immediate must stay ADD.
  function automatic logic [3:0] alu_sel(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
    logic [3:0] sel;
    case (op)
      OPC_OP:     sel = {f7b5 & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
      OPC_OP_IMM: sel = {f7b5 & (f3 == 3'b101), f3};
      OPC_BRANCH: sel = ALU_SUB;
      default:    sel = ALU_ADD;
    endcase
    return sel;
  endfunction

  // Decode fields come straight from the IR while in DECODE, then from the latch.
  assign dec_op    = (state == S_DECODE) ? opcode    : op_q;
  assign dec_f3    = (state == S_DECODE) ? funct3    : f3_q;
  assign dec_f7b5  = (state == S_DECODE) ? funct7[5] : f7b5_q;
  assign xfer_done = ctl_q.mem_req & mem_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;
  logic [5:0]      unused_bits;
  assign unused_bits = {funct7[6], funct7[4:0]};
  assign timeout = ctl_q.mem_req & ~mem_ready & (wait_cnt == TO_W'(MEM_TIMEOUT));

  // Count wait cycles of the current request; any state change starts a new request window.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (nxt != state) begin
      wait_cnt <= '0;
    end else if (ctl_q.mem_req & ~mem_ready) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end
`else
  logic [6:0] unused_bits;
  assign unused_bits = {funct7[6], funct7[4:0], MEM_TIMEOUT[0]};
  assign timeout = 1'b0;
`endif

  // Next state and retirement strobe.
  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_HALT:   if (go) nxt = S_FETCH;
      S_FETCH: begin
        if (xfer_done)    nxt = S_DECODE;
        else if (timeout) nxt = S_TRAP;
      end
      S_DECODE: nxt = is_legal(opcode) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          // FENCE/SYSTEM are legal but have no side effects in this core.
          OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          OPC_LOAD, OPC_STORE: nxt = S_MEM;
          default:             nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (xfer_done) begin
          if (op_q == OPC_STORE) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else begin
            nxt = S_WB;
          end
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      default: nxt = S_TRAP;
    endcase
  end

  // Output values for the state being entered, registered alongside the state.
  always_comb begin
    nxt_ctl = CTL_IDLE;
    case (nxt)
      S_FETCH: nxt_ctl.mem_req = 1'b1;
      S_EXEC: begin
        nxt_ctl.alu_op  = alu_sel(dec_op, dec_f3, dec_f7b5);
        nxt_ctl.alu_src = (dec_op != OPC_OP) && (dec_op != OPC_BRANCH);
        case (dec_op)
          OPC_BRANCH: begin
            nxt_ctl.pc_src = 2'b01;
            nxt_ctl.branch = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            nxt_ctl.pc_src        = (dec_op == OPC_JAL) ? 2'b01 : 2'b10;
            nxt_ctl.pc_write      = 1'b1;
            nxt_ctl.reg_write     = 1'b1;
            nxt_ctl.reg_write_src = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        nxt_ctl.alu_op   = alu_sel(dec_op, dec_f3, dec_f7b5);
        nxt_ctl.alu_src  = 1'b1;
        nxt_ctl.mem_req  = 1'b1;
        nxt_ctl.mem_we   = (dec_op == OPC_STORE);
        nxt_ctl.mem_size = dec_f3;
      end
      S_WB: begin
        nxt_ctl.alu_op    = alu_sel(dec_op, dec_f3, dec_f7b5);
        nxt_ctl.alu_src   = (dec_op != OPC_OP);
        nxt_ctl.reg_write = 1'b1;
        if (dec_op == OPC_LOAD)     nxt_ctl.reg_write_src = 2'b01;
        else if (dec_op == OPC_LUI) nxt_ctl.reg_write_src = 2'b11;
        else                        nxt_ctl.reg_write_src = 2'b00;
      end
      S_TRAP: nxt_ctl.trap = 1'b1;
      default: ;
    endcase
  end

  // State, registered outputs, decode latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (RESET_FETCH != 0) ? S_FETCH : S_HALT;
      ctl_q   <= CTL_IDLE;
      op_q    <= '0;
      f3_q    <= '0;
      f7b5_q  <= 1'b0;
      instret <= '0;
    end else begin
      state <= nxt;
      ctl_q <= nxt_ctl;
      if (state == S_DECODE) begin
        op_q   <= opcode;
        f3_q   <= funct3;
        f7b5_q <= funct7[5];
      end
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign mem_req       = ctl_q.mem_req;
  assign mem_we        = ctl_q.mem_we;
  assign mem_size      = ctl_q.mem_size;
  assign pc_src        = ctl_q.pc_src;
  assign alu_src       = ctl_q.alu_src;
  assign alu_op        = ctl_q.alu_op;
  assign reg_write     = ctl_q.reg_write;
  assign reg_write_src = ctl_q.reg_write_src;
  assign trap          = ctl_q.trap;
  assign state_o       = state;
  // Fetch completion writes IR and advances PC in the same cycle as the handshake.
  assign ir_write      = (state == S_FETCH) & xfer_done;
  assign pc_write      = ((state == S_FETCH) & xfer_done) | ctl_q.pc_write | (ctl_q.branch & branch_taken);

endmodule
